// File: rtl/md5_iter_hasher.sv
// md5_iter_hasher: folded, multi-chunk MD5 compression engine.
//
// Takes pre-padded 512-bit chunks from the front end and evaluates the 64 MD5
// steps at ROUNDS_PER_CYCLE steps per clock, which gives ITERS = 64 / ROUNDS_PER_CYCLE
// RUN cycles per chunk. Chaining state is kept between chunks, so a message can span
// several chunks. A digest is only produced for a chunk flagged in_last.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   chunk handshake; in_ready is high only in IDLE
//   in_chunk [511:0]      message block, word i = in_chunk[32i+31:32i], little-endian bytes
//   in_first              reload chaining state with the IV before this chunk
//   in_last               produce a digest after this chunk
//   out_valid / out_ready digest handshake; out_valid is high only in DONE
//   out_a..out_d [31:0]   final chaining words, held stable until accepted
//   busy                  high in RUN, ADD or DONE
//
// Optional build macro MD5_MIDSTATE_EN adds iv_a..iv_d [31:0]. These replace the
// standard IV on an in_first handshake, so a saved midstate can be resumed.
// Reset always loads the standard IV.
module md5_iter_hasher #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_chunk,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [31:0]  out_c,
  output logic [31:0]  out_d,
`ifdef MD5_MIDSTATE_EN
  input  logic [31:0]  iv_a,
  input  logic [31:0]  iv_b,
  input  logic [31:0]  iv_c,
  input  logic [31:0]  iv_d,
`endif
  output logic         busy
);

  localparam int unsigned ITERS   = 64 / ROUNDS_PER_CYCLE;
  localparam int unsigned CntW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int unsigned RpcLog2 = $clog2(ROUNDS_PER_CYCLE);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : gen_rpc_check
    $error("md5_iter_hasher: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Standard IV, packed {A, B, C, D}.
  localparam logic [127:0] Iv = 128'h67452301_efcdab89_98badcfe_10325476;

  // Sine-derived additive constants, indexed by step.
  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts: the shift repeats every 4 steps within a round, so index by
  // {round, step[1:0]}.
  localparam logic [4:0] S [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  // One MD5 step on a packed {A, B, C, D} state.
  function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] g,
                                            input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, m, sum;
    logic [3:0]  lo, idx;
    logic [63:0] rot;
    {a, b, c, d} = st;
    lo = g[3:0];
    // Message index arithmetic wraps at 4 bits, which gives the mod-16 directly.
    unique case (g[5:4])
      2'd0: begin
        f   = (b & c) | (~b & d);
        idx = lo;
      end
      2'd1: begin
        f   = (d & b) | (~d & c);
        idx = lo * 4'd5 + 4'd1;
      end
      2'd2: begin
        f   = b ^ c ^ d;
        idx = lo * 4'd3 + 4'd5;
      end
      default: begin
        f   = c ^ (b | ~d);
        idx = lo * 4'd7;
      end
    endcase
    m   = blk[32*idx +: 32];
    sum = a + f + K[g] + m;
    // Rotate-left via a doubled word; the upper half holds the result.
    rot = {sum, sum} << S[{g[5:4], g[1:0]}];
    return {d, b + rot[63:32], b, c};
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [511:0]    chunk_q, chunk_d;
  logic            last_q, last_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    chain_q, chain_d;
  logic [127:0]    dig_q, dig_d;

  logic [127:0]    seed;
  logic [127:0]    round_st;
  logic [127:0]    sum_st;
  logic [5:0]      step_base;

`ifdef MD5_MIDSTATE_EN
  assign seed = {iv_a, iv_b, iv_c, iv_d};
`else
  assign seed = Iv;
`endif

  assign step_base = 6'(cnt_q) << RpcLog2;

  // Folded round engine: ROUNDS_PER_CYCLE chained steps per clock.
  always_comb begin
    round_st = work_q;
    for (int r = 0; r < int'(ROUNDS_PER_CYCLE); r++) begin
      round_st = md5_step(round_st, step_base + 6'(r), chunk_q);
    end
  end

  // Per-word feed-forward add.
  assign sum_st = {chain_q[127:96] + work_q[127:96],
                   chain_q[95:64]  + work_q[95:64],
                   chain_q[63:32]  + work_q[63:32],
                   chain_q[31:0]   + work_q[31:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chunk_d   = chunk_q;
    last_d    = last_q;
    work_d    = work_q;
    chain_d   = chain_q;
    dig_d     = dig_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          chunk_d = in_chunk;
          last_d  = in_last;
          cnt_d   = '0;
          if (in_first) begin
            chain_d = seed;
            work_d  = seed;
          end else begin
            work_d  = chain_q;
          end
          state_d = StRun;
        end
      end
      StRun: begin
        work_d = round_st;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITERS - 1)) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        chain_d = sum_st;
        if (last_q) begin
          dig_d   = sum_st;
          state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      chunk_q <= '0;
      last_q  <= 1'b0;
      work_q  <= '0;
      chain_q <= Iv;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chunk_q <= chunk_d;
      last_q  <= last_d;
      work_q  <= work_d;
      chain_q <= chain_d;
      dig_q   <= dig_d;
    end
  end

  assign out_a = dig_q[127:96];
  assign out_b = dig_q[95:64];
  assign out_c = dig_q[63:32];
  assign out_d = dig_q[31:0];

endmodule

// File: tb/tb_md5_iter_hasher.sv
// Directed bench for md5_iter_hasher. Three instances: index 0 with 1 step/clock,
// index 1 with 4 steps/clock, index 2 with 2 steps/clock. Expected digests are the
// published MD5 results written as little-endian words.
module tb_md5_iter_hasher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic [2:0]        in_valid, in_ready, in_first, in_last;
  logic [2:0]        out_valid, out_ready, busy;
  logic [2:0][511:0] in_chunk;
  logic [2:0][31:0]  out_a, out_b, out_c, out_d;
`ifdef MD5_MIDSTATE_EN
  logic [2:0][31:0]  iv_a, iv_b, iv_c, iv_d;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int unsigned Rpc = (i == 0) ? 1 : ((i == 1) ? 4 : 2);
    md5_iter_hasher #(.ROUNDS_PER_CYCLE(Rpc)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_chunk  (in_chunk[i]),
      .in_first  (in_first[i]),
      .in_last   (in_last[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_a     (out_a[i]),
      .out_b     (out_b[i]),
      .out_c     (out_c[i]),
      .out_d     (out_d[i]),
`ifdef MD5_MIDSTATE_EN
      .iv_a      (iv_a[i]),
      .iv_b      (iv_b[i]),
      .iv_c      (iv_c[i]),
      .iv_d      (iv_d[i]),
`endif
      .busy      (busy[i])
    );
  end

  localparam logic [127:0] DEmpty = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] DHello = 128'hb18d0ab1_4175e064_9ba9b705_e53f2ee7;
  localparam logic [127:0] DRfc   = 128'ha2f4ed57_55c9e32b_2eda49ac_7ab60721;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_digest(input string tag, input int u, input logic [127:0] exp);
    check({tag, ".a"}, out_a[u], exp[127:96]);
    check({tag, ".b"}, out_b[u], exp[95:64]);
    check({tag, ".c"}, out_c[u], exp[63:32]);
    check({tag, ".d"}, out_d[u], exp[31:0]);
  endtask

  // Offer a chunk and return at the falling edge after the accepting edge.
  task automatic offer(input string tag, input int u, input logic [511:0] ch,
                       input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid[u] = 1'b1;
    in_chunk[u] = ch;
    in_first[u] = f;
    in_last[u]  = l;
    while (in_ready[u] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".accept"}, 32'(in_ready[u]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_chunk[u] = {16{32'hdeadbeef}};  // must not leak into the latched chunk
    in_first[u] = 1'b0;
    in_last[u]  = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, then compare the digest.
  task automatic wait_digest(input string tag, input int u, input int exp_lat,
                             input logic [127:0] exp);
    int n = 0;
    while (out_valid[u] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check_digest(tag, u, exp);
  endtask

  task automatic ack(input string tag, input int u);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check({tag, ".ack_valid"}, 32'(out_valid[u]), 32'd0);
    check({tag, ".ack_ready"}, 32'(in_ready[u]), 32'd1);
  endtask

  logic [511:0] c_empty, c_hello, c_rfc1, c_rfc2;
  logic [31:0]  pat [5];
  logic [127:0] mid;
  int           seen;

  initial begin
    // Chunks built word by word (little-endian bytes inside each word).
    c_empty = 512'h80;
    c_hello = '0;
    c_hello[31:0]    = 32'h6c6c6548;  // "Hell"
    c_hello[63:32]   = 32'h6f57206f;  // "o Wo"
    c_hello[95:64]   = 32'h80646c72;  // "rld" + pad byte
    c_hello[479:448] = 32'h00000058;  // 88 bits
    pat[0] = 32'h34333231;            // "1234"
    pat[1] = 32'h38373635;            // "5678"
    pat[2] = 32'h32313039;            // "9012"
    pat[3] = 32'h36353433;            // "3456"
    pat[4] = 32'h30393837;            // "7890"
    for (int i = 0; i < 16; i++) c_rfc1[32*i +: 32] = pat[i % 5];
    c_rfc2 = '0;
    for (int i = 0; i < 4; i++) c_rfc2[32*i +: 32] = pat[i + 1];
    c_rfc2[159:128] = 32'h00000080;
    c_rfc2[479:448] = 32'h00000280;   // 640 bits

    reset_n   = 1'b0;
    in_valid  = '0;
    in_first  = '0;
    in_last   = '0;
    out_ready = '0;
    in_chunk  = '0;
`ifdef MD5_MIDSTATE_EN
    for (int i = 0; i < 3; i++) begin
      {iv_a[i], iv_b[i], iv_c[i], iv_d[i]} = 128'h67452301_efcdab89_98badcfe_10325476;
    end
`endif
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst.in_ready", 32'(in_ready[0]), 32'd1);
    check("rst.out_valid", 32'(out_valid[0]), 32'd0);
    check("rst.busy", 32'(busy[0]), 32'd0);
    check_digest("rst", 0, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty message, 1 step/clock.
    offer("empty", 0, c_empty, 1'b1, 1'b1);
    check("empty.busy", 32'(busy[0]), 32'd1);
    check("empty.in_ready_run", 32'(in_ready[0]), 32'd0);
    wait_digest("empty", 0, 65, DEmpty);
    ack("empty", 0);

    // "Hello World", 4 steps/clock.
    offer("hello", 1, c_hello, 1'b1, 1'b1);
    wait_digest("hello", 1, 17, DHello);
    ack("hello", 1);

    // Two-chunk RFC vector, 2 steps/clock; no digest after the first chunk.
    offer("rfc1", 2, c_rfc1, 1'b1, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[2] === 1'b1) seen++;
    end
    check("rfc1.no_digest", 32'(seen), 32'd0);
    check("rfc1.idle_again", 32'(in_ready[2]), 32'd1);
    offer("rfc2", 2, c_rfc2, 1'b0, 1'b1);
    wait_digest("rfc", 2, 33, DRfc);
    ack("rfc", 2);

    // Backpressure: digest held for 10 cycles while a second chunk waits.
    offer("bp", 0, c_empty, 1'b1, 1'b1);
    wait_digest("bp", 0, 65, DEmpty);
    in_valid[0] = 1'b1;
    in_chunk[0] = c_hello;
    in_first[0] = 1'b1;
    in_last[0]  = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
          {out_a[0], out_b[0], out_c[0], out_d[0]} !== DEmpty) seen++;
    end
    check("bp.hold_stable", 32'(seen), 32'd0);
    check("bp.hold_in_ready", 32'(in_ready[0]), 32'd0);
    check_digest("bp.hold", 0, DEmpty);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp.release_valid", 32'(out_valid[0]), 32'd0);
    check("bp.release_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);  // the held chunk is accepted here
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_first[0] = 1'b0;
    in_last[0]  = 1'b0;
    wait_digest("bp2", 0, 65, DHello);
    ack("bp2", 0);

    // Reset in the middle of RUN aborts the job.
    offer("abort", 0, c_empty, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("abort.busy_before", 32'(busy[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort.busy_async", 32'(busy[0]), 32'd0);
    check("abort.out_a_cleared", out_a[0], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen++;
    end
    check("abort.no_digest", 32'(seen), 32'd0);
    // Without in_first the job uses the chaining state, which reset set back to the IV.
    offer("reissue", 0, c_empty, 1'b0, 1'b1);
    wait_digest("reissue", 0, 65, DEmpty);
    ack("reissue", 0);

`ifdef MD5_MIDSTATE_EN
    // Chunk 1 as a stand-alone message leaves the chaining value in out_a..d.
    offer("mid1", 0, c_rfc1, 1'b1, 1'b1);
    seen = 0;
    while (out_valid[0] !== 1'b1 && seen < 300) begin
      @(negedge clk);
      seen++;
    end
    check("mid1.latency", 32'(seen), 32'd65);
    mid = {out_a[0], out_b[0], out_c[0], out_d[0]};
    ack("mid1", 0);
    {iv_a[0], iv_b[0], iv_c[0], iv_d[0]} = mid;
    offer("mid2", 0, c_rfc2, 1'b1, 1'b1);
    wait_digest("mid", 0, 65, DRfc);
    ack("mid", 0);
`else
    mid = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
